sram_ctrl_s3: RTL and testbench

SRAM_CTRL_S3 -- requirements
Module: sram_ctrl_s3

---
 rtl/sram_ctrl_pkg.sv | 32 +++
 rtl/sram_ctrl_s3.sv | 123 ++++++++++++
 tb/tb_sram_ctrl_s3.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants, FSM state encoding and request record for the
// s3board dual asynchronous-SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned CS_BIT  = 18;
    localparam int unsigned WADDR_W = 18;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BE_W    = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } sram_req_t;

    // The strobe phase ends when the counter reaches zero, so it is loaded with WAIT-1.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_cycles);
        return CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_s3.sv
// Single-port controller for the two 256Kx16 asynchronous SRAMs on the s3board:
// SETUP / ACCESS(WAIT) / HOLD(write only) / DONE sequencing with byte enables.
module sram_ctrl_s3
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [BE_W-1:0]     be,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                busy,
    output logic [WADDR_W-1:0]  ram_a,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    inout  wire  [DATA_W-1:0]   ram1_io,
    output logic                ram1_ce_n,
    output logic                ram1_ub_n,
    output logic                ram1_lb_n,
    inout  wire  [DATA_W-1:0]   ram2_io,
    output logic                ram2_ce_n,
    output logic                ram2_ub_n,
    output logic                ram2_lb_n
);

    state_e             state_q, state_d;
    sram_req_t          req_q,   req_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               active;
    logic               sel2;
    logic               io_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        unique case (state_q)
            // DONE accepts a new request exactly like IDLE for back-to-back accesses.
            IDLE, DONE: begin
                if (req) begin
                    req_d.wr    = wr;
                    req_d.addr  = addr;
                    req_d.wdata = wdata;
                    req_d.be    = be;
                    state_d     = SETUP;
                end else begin
                    state_d     = IDLE;
                end
            end
            SETUP: begin
                cnt_d   = wait_load(WAIT);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (req_q.wr) begin
                        state_d = HOLD;
                    end else begin
                        rdata_d = sel2 ? ram2_io : ram1_io;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        active    = (state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD);
        sel2      = req_q.addr[CS_BIT];
        io_en     = active && req_q.wr;

        busy      = active;
        ack       = (state_q == DONE);
        rdata     = rdata_q;
        ram_a     = req_q.addr[WADDR_W-1:0];

        // oe_n and we_n are gated by opposite values of wr, so they can never overlap.
        ram_oe_n  = !(!req_q.wr && ((state_q == SETUP) || (state_q == ACCESS)));
        ram_we_n  = !(req_q.wr && (state_q == ACCESS));

        ram1_ce_n = !(active && !sel2);
        ram1_ub_n = !(active && !sel2 && req_q.be[1]);
        ram1_lb_n = !(active && !sel2 && req_q.be[0]);
        ram2_ce_n = !(active && sel2);
        ram2_ub_n = !(active && sel2 && req_q.be[1]);
        ram2_lb_n = !(active && sel2 && req_q.be[0]);
    end

    assign ram1_io = (io_en && !sel2) ? req_q.wdata : 'z;
    assign ram2_io = (io_en &&  sel2) ? req_q.wdata : 'z;

endmodule

// File: tb/tb_sram_ctrl_s3.sv
// Bench for sram_ctrl_s3 against a behavioural model of the two s3board SRAMs,
// with a reference memory feeding an expected-result queue.
module tb_sram_ctrl_s3;

    localparam int unsigned WAIT   = 1;
    localparam int          RD_LAT = WAIT + 2;
    localparam int          WR_LAT = WAIT + 3;
    localparam int unsigned DEPTH  = 262144;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        req     = 1'b0;
    logic        wr      = 1'b0;
    logic [18:0] addr    = '0;
    logic [15:0] wdata   = '0;
    logic [1:0]  be      = '0;

    logic [15:0] rdata;
    logic        ack, busy;
    logic [17:0] ram_a;
    logic        ram_oe_n, ram_we_n;
    logic        ram1_ce_n, ram1_ub_n, ram1_lb_n;
    logic        ram2_ce_n, ram2_ub_n, ram2_lb_n;
    tri1  [15:0] ram1_io;
    tri1  [15:0] ram2_io;

    always #5 clk = ~clk;

    sram_ctrl_s3 #(.WAIT(WAIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .rdata     (rdata),
        .ack       (ack),
        .busy      (busy),
        .ram_a     (ram_a),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram1_io   (ram1_io),
        .ram1_ce_n (ram1_ce_n),
        .ram1_ub_n (ram1_ub_n),
        .ram1_lb_n (ram1_lb_n),
        .ram2_io   (ram2_io),
        .ram2_ce_n (ram2_ce_n),
        .ram2_ub_n (ram2_ub_n),
        .ram2_lb_n (ram2_lb_n)
    );

    // Asynchronous SRAM model: byte-lane reads while oe_n is low, level-sensitive writes.
    logic [15:0] mem1 [0:DEPTH-1];
    logic [15:0] mem2 [0:DEPTH-1];
    logic        rd1, rd2;

    assign rd1 = !ram1_ce_n && !ram_oe_n && ram_we_n;
    assign rd2 = !ram2_ce_n && !ram_oe_n && ram_we_n;
    assign ram1_io[15:8] = (rd1 && !ram1_ub_n) ? mem1[ram_a][15:8] : 8'hzz;
    assign ram1_io[7:0]  = (rd1 && !ram1_lb_n) ? mem1[ram_a][7:0]  : 8'hzz;
    assign ram2_io[15:8] = (rd2 && !ram2_ub_n) ? mem2[ram_a][15:8] : 8'hzz;
    assign ram2_io[7:0]  = (rd2 && !ram2_lb_n) ? mem2[ram_a][7:0]  : 8'hzz;

    always @(negedge clk) begin
        if (!ram1_ce_n && !ram_we_n) begin
            if (!ram1_ub_n) mem1[ram_a][15:8] <= ram1_io[15:8];
            if (!ram1_lb_n) mem1[ram_a][7:0]  <= ram1_io[7:0];
        end
        if (!ram2_ce_n && !ram_we_n) begin
            if (!ram2_ub_n) mem2[ram_a][15:8] <= ram2_io[15:8];
            if (!ram2_lb_n) mem2[ram_a][7:0]  <= ram2_io[7:0];
        end
    end

    logic [15:0] ref1 [0:DEPTH-1];
    logic [15:0] ref2 [0:DEPTH-1];

    typedef struct {
        logic        is_rd;
        logic [15:0] data;
        int          lat;
    } exp_t;

    typedef struct {
        logic        w;
        logic [18:0] a;
        logic [15:0] d;
        logic [1:0]  b;
    } acc_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [15:0] init_word(input logic chip, input int unsigned i);
        return 16'(i) ^ (chip ? 16'hC3A5 : 16'h5A3C);
    endfunction

    // Issues one access, records the expectation and watches strobes until ack.
    // seen: [0]ce1 [1]ce2 [2]ub1 [3]lb1 [4]ub2 [5]lb2 [6]oe&we overlap [7]we, each = went low.
    task automatic run_access(input logic w, input logic [18:0] a, input logic [15:0] d,
                              input logic [1:0] b, output int lat, output logic [7:0] seen);
        logic [15:0] cur;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d; be = b;
        cur = a[18] ? ref2[a[17:0]] : ref1[a[17:0]];
        if (w) begin
            if (b[1]) cur[15:8] = d[15:8];
            if (b[0]) cur[7:0]  = d[7:0];
            if (a[18]) ref2[a[17:0]] = cur;
            else       ref1[a[17:0]] = cur;
            sb_q.push_back('{1'b0, 16'h0000, WR_LAT});
        end else begin
            sb_q.push_back('{(b == 2'b11), cur, RD_LAT});
        end
        @(posedge clk);
        #1;
        req = 1'b0; wr = ~w; addr = ~a; wdata = ~d; be = ~b;
        lat  = -1;
        seen = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            seen |= {~ram_we_n, ~ram_oe_n & ~ram_we_n, ~ram2_lb_n, ~ram2_ub_n,
                     ~ram1_lb_n, ~ram1_ub_n, ~ram2_ce_n, ~ram1_ce_n};
            if (ack) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", ack); else n_pass++;
        n_checks++; if (rdata !== 16'h0000) $display("FAIL rst_rdata: got %h want 0000", rdata); else n_pass++;
        n_checks++; if (ram_a !== 18'h0) $display("FAIL rst_ram_a: got %h want 00000", ram_a); else n_pass++;
        n_checks++; if ({ram_oe_n, ram_we_n} !== 2'b11) $display("FAIL rst_oe_we: got %b want 11", {ram_oe_n, ram_we_n}); else n_pass++;
        n_checks++;
        if ({ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n} !== 6'b111111)
            $display("FAIL rst_chip_strobes: got %b want 111111",
                     {ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n});
        else n_pass++;
        n_checks++; if (ram1_io !== 16'hFFFF) $display("FAIL rst_io1_z: got %h want released (FFFF)", ram1_io); else n_pass++;
        n_checks++; if (ram2_io !== 16'hFFFF) $display("FAIL rst_io2_z: got %h want released (FFFF)", ram2_io); else n_pass++;
        req = 1'b1; wr = 1'b1; addr = 19'h00042; wdata = 16'h9999; be = 2'b11;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_req_ignored: got busy %b want 0", busy); else n_pass++;
        req = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({busy, ack} !== 2'b00) $display("FAIL rst_release_idle: got %b want 00", {busy, ack}); else n_pass++;
    endtask

    task automatic test_write_read();
        acc_t seq [2];
        exp_t e;
        int   lat;
        logic [7:0] seen;
        seq = '{'{1'b1, 19'h00123, 16'h0ABC, 2'b11}, '{1'b0, 19'h00123, 16'h0000, 2'b11}};
        foreach (seq[i]) begin
            run_access(seq[i].w, seq[i].a, seq[i].d, seq[i].b, lat, seen);
            e = sb_q.pop_front();
            n_checks++; if (lat !== e.lat) $display("FAIL wr_rd_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
            if (e.is_rd) begin
                n_checks++; if (rdata !== e.data) $display("FAIL wr_rd_data[%0d]: got %h want %h", i, rdata, e.data); else n_pass++;
            end
            n_checks++; if (seen[6] !== 1'b0) $display("FAIL wr_rd_oe_we_overlap[%0d]: got 1 want 0", i); else n_pass++;
        end
    endtask

    task automatic test_byte_write();
        acc_t seq [3];
        exp_t e;
        int   lat;
        logic [7:0] seen;
        seq = '{'{1'b1, 19'h00010, 16'hFFFF, 2'b11}, '{1'b1, 19'h00010, 16'h1234, 2'b01},
                '{1'b0, 19'h00010, 16'h0000, 2'b11}};
        foreach (seq[i]) begin
            run_access(seq[i].w, seq[i].a, seq[i].d, seq[i].b, lat, seen);
            e = sb_q.pop_front();
            n_checks++; if (lat !== e.lat) $display("FAIL byte_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
            if (e.is_rd) begin
                n_checks++; if (rdata !== e.data) $display("FAIL byte_data[%0d]: got %h want %h", i, rdata, e.data); else n_pass++;
            end
            if (i == 1) begin
                n_checks++; if (seen[3:2] !== 2'b10) $display("FAIL byte_lanes: got lb1/ub1 active %b want 10", seen[3:2]); else n_pass++;
            end
        end
    endtask

    task automatic test_chip_select();
        acc_t seq [3];
        exp_t e;
        int   lat;
        logic [7:0] seen;
        seq = '{'{1'b1, 19'h40005, 16'h5555, 2'b11}, '{1'b0, 19'h40005, 16'h0000, 2'b11},
                '{1'b0, 19'h00005, 16'h0000, 2'b11}};
        foreach (seq[i]) begin
            run_access(seq[i].w, seq[i].a, seq[i].d, seq[i].b, lat, seen);
            e = sb_q.pop_front();
            n_checks++; if (lat !== e.lat) $display("FAIL cs_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
            if (e.is_rd) begin
                n_checks++; if (rdata !== e.data) $display("FAIL cs_data[%0d]: got %h want %h", i, rdata, e.data); else n_pass++;
            end
            if (i == 0) begin
                n_checks++; if (seen[1:0] !== 2'b10) $display("FAIL cs_ce: got ce2/ce1 active %b want 10", seen[1:0]); else n_pass++;
                n_checks++; if (mem2[5] !== 16'h5555) $display("FAIL cs_ram2_word5: got %h want 5555", mem2[5]); else n_pass++;
                n_checks++; if (mem1[5] !== ref1[5]) $display("FAIL cs_ram1_word5: got %h want %h", mem1[5], ref1[5]); else n_pass++;
            end
        end
    endtask

    task automatic test_be_zero();
        acc_t seq [4];
        exp_t e;
        int   lat;
        logic [7:0] seen;
        seq = '{'{1'b1, 19'h00020, 16'h7E7E, 2'b11}, '{1'b1, 19'h00020, 16'h0000, 2'b00},
                '{1'b0, 19'h00020, 16'h0000, 2'b00}, '{1'b0, 19'h00020, 16'h0000, 2'b11}};
        foreach (seq[i]) begin
            run_access(seq[i].w, seq[i].a, seq[i].d, seq[i].b, lat, seen);
            e = sb_q.pop_front();
            n_checks++; if (lat !== e.lat) $display("FAIL be0_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
            if (e.is_rd) begin
                n_checks++; if (rdata !== e.data) $display("FAIL be0_data[%0d]: got %h want %h", i, rdata, e.data); else n_pass++;
            end
            if (seq[i].b == 2'b00) begin
                n_checks++; if (seen[5:2] !== 4'b0000) $display("FAIL be0_strobes[%0d]: got %b want 0000", i, seen[5:2]); else n_pass++;
            end
        end
    endtask

    task automatic test_boundary();
        acc_t seq [4];
        exp_t e;
        int   lat;
        logic [7:0] seen;
        seq = '{'{1'b1, 19'h3FFFF, 16'hA1A1, 2'b11}, '{1'b1, 19'h7FFFF, 16'hB2B2, 2'b11},
                '{1'b0, 19'h3FFFF, 16'h0000, 2'b11}, '{1'b0, 19'h7FFFF, 16'h0000, 2'b11}};
        foreach (seq[i]) begin
            run_access(seq[i].w, seq[i].a, seq[i].d, seq[i].b, lat, seen);
            e = sb_q.pop_front();
            n_checks++; if (lat !== e.lat) $display("FAIL top_addr_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
            if (e.is_rd) begin
                n_checks++; if (rdata !== e.data) $display("FAIL top_addr_data[%0d]: got %h want %h", i, rdata, e.data); else n_pass++;
            end
        end
        n_checks++; if (mem1[0] !== ref1[0]) $display("FAIL top_addr_wrap1: got %h want %h", mem1[0], ref1[0]); else n_pass++;
        n_checks++; if (mem2[0] !== ref2[0]) $display("FAIL top_addr_wrap2: got %h want %h", mem2[0], ref2[0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [18:0] a [3];
        int          ack_cyc [3];
        int          n_ack = 0;
        int          extra = 0;
        logic        drop = 1'b0;
        exp_t        e;
        a = '{19'h00123, 19'h00010, 19'h40005};
        @(negedge clk);
        req = 1'b1; wr = 1'b0; be = 2'b11; addr = a[0];
        sb_q.push_back('{1'b1, ref1[a[0][17:0]], RD_LAT});
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack) begin
                ack_cyc[n_ack] = k;
                n_ack++;
                e = sb_q.pop_front();
                n_checks++; if (rdata !== e.data) $display("FAIL b2b_data[%0d]: got %h want %h", n_ack - 1, rdata, e.data); else n_pass++;
                if (n_ack == 3) break;
                addr = a[n_ack];
                sb_q.push_back('{1'b1, a[n_ack][18] ? ref2[a[n_ack][17:0]] : ref1[a[n_ack][17:0]], RD_LAT});
                drop = (n_ack == 2);
            end
            if (drop) begin
                @(posedge clk);
                #1 req = 1'b0;
                drop = 1'b0;
            end
        end
        req = 1'b0;
        n_checks++; if (n_ack !== 3) $display("FAIL b2b_ack_count: got %0d want 3", n_ack); else n_pass++;
        if (n_ack == 3) begin
            n_checks++; if (ack_cyc[0] !== RD_LAT) $display("FAIL b2b_first_lat: got %0d want %0d", ack_cyc[0], RD_LAT); else n_pass++;
            n_checks++; if (ack_cyc[1] - ack_cyc[0] !== 3) $display("FAIL b2b_gap1: got %0d want 3", ack_cyc[1] - ack_cyc[0]); else n_pass++;
            n_checks++; if (ack_cyc[2] - ack_cyc[1] !== 3) $display("FAIL b2b_gap2: got %0d want 3", ack_cyc[2] - ack_cyc[1]); else n_pass++;
        end
        repeat (8) begin
            @(negedge clk);
            if (ack) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL b2b_extra_ack: got %0d want 0", extra); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int   n_ack = 0;
        int   ack_at = -1;
        exp_t e;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 19'h00123; wdata = 16'h0000; be = 2'b11;
        sb_q.push_back('{1'b1, ref1[18'h00123], RD_LAT});
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL busy_high: got %b want 1", busy); else n_pass++;
        req = 1'b1; wr = 1'b1; addr = 19'h00123; wdata = 16'hDEAD; be = 2'b11;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 2; k <= 14; k++) begin
            @(negedge clk);
            if (ack) begin
                n_ack++;
                if (ack_at < 0) begin
                    ack_at = k;
                    e = sb_q.pop_front();
                    n_checks++; if (rdata !== e.data) $display("FAIL busy_data: got %h want %h", rdata, e.data); else n_pass++;
                end
            end
        end
        n_checks++; if (n_ack !== 1) $display("FAIL busy_ack_count: got %0d want 1", n_ack); else n_pass++;
        n_checks++; if (ack_at !== RD_LAT) $display("FAIL busy_lat: got %0d want %0d", ack_at, RD_LAT); else n_pass++;
        n_checks++; if (mem1[18'h00123] !== ref1[18'h00123]) $display("FAIL busy_no_write: got %h want %h", mem1[18'h00123], ref1[18'h00123]); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int n_ack = 0;
        int n_busy = 0;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 19'h00050; wdata = 16'h0F0F; be = 2'b11;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        n_checks++; if (ram1_io !== 16'h0F0F) $display("FAIL mid_setup_io: got %h want 0F0F", ram1_io); else n_pass++;
        @(negedge clk);
        n_checks++; if (ram_we_n !== 1'b0) $display("FAIL mid_access_we: got %b want 0", ram_we_n); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (ram_we_n !== 1'b1) $display("FAIL mid_rst_we: got %b want 1", ram_we_n); else n_pass++;
        n_checks++; if (ram1_io !== 16'hFFFF) $display("FAIL mid_rst_io_z: got %h want released (FFFF)", ram1_io); else n_pass++;
        n_checks++; if ({busy, ram1_ce_n} !== 2'b01) $display("FAIL mid_rst_busy_ce: got %b want 01", {busy, ram1_ce_n}); else n_pass++;
        if (ack) n_ack++;
        repeat (3) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ack) n_ack++;
            if (busy) n_busy++;
        end
        n_checks++; if (n_ack !== 0) $display("FAIL mid_rst_no_ack: got %0d acks want 0", n_ack); else n_pass++;
        n_checks++; if (n_busy !== 0) $display("FAIL mid_rst_busy_after: got %0d busy cycles want 0", n_busy); else n_pass++;
        n_checks++; if (rdata !== 16'h0000) $display("FAIL mid_rst_rdata: got %h want 0000", rdata); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem1[i[17:0]] <= init_word(1'b0, i);
            mem2[i[17:0]] <= init_word(1'b1, i);
            ref1[i[17:0]]  = init_word(1'b0, i);
            ref2[i[17:0]]  = init_word(1'b1, i);
        end
        test_reset();
        test_write_read();
        test_byte_write();
        test_chip_select();
        test_be_zero();
        test_boundary();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
